uart_tx_cfg: RTL
================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of baud divisor.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of 2 and at least 2.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port cfg_div  input  DIV_W  bit period minus one, in clk cycles; value 0 is treated as 1.
REQ-006 SHALL have port cfg_nbits  input  2  data bits: 00=5, 01=6, 10=7, 11=8.
REQ-007 SHALL have port cfg_parity  input  2  parity mode: 00=none, 01=even, 10=odd, 11=none.
REQ-008 SHALL have port cfg_stop2  input  1  0 selects 1 stop bit; 1 selects 2 stop bits.
REQ-009 SHALL have port s_valid  input  1  write request.
REQ-010 SHALL have port s_data  input  8  byte to send; bits above nbits are ignored.
REQ-011 SHALL have port s_ready  output  1  FIFO not full.
REQ-012 SHALL have port uart_tx  output  1  registered serial line; idle level is high.
REQ-013 SHALL have port tx_busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty.
REQ-014 SHALL have port fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-015 SHALL write s_data into the FIFO on each clk edge where s_valid and s_ready are both high; s_ready is defined as not full.
REQ-016 SHALL have an FSM with states IDLE, START, DATA, PARITY and STOP.
REQ-017 SHALL, in IDLE with the FIFO non-empty, at the next edge pop one word, latch all cfg_* inputs, enter START and drive uart_tx to 0 at that same edge.
REQ-018 SHALL hold each bit for exactly max(cfg_div,1)+1 clk cycles, timed by a bit counter that restarts at every state entry and bit boundary.
REQ-019 SHALL, in DATA, send the latched word LSB first for nbits bit periods, then go to PARITY if parity is enabled, otherwise to STOP.
REQ-020 SHALL, in PARITY, send one bit: the XOR of the sent data bits for even parity, or its inverse for odd parity.
REQ-021 SHALL, in STOP, drive the line high for 1 or 2 bit periods according to the latched cfg_stop2.
REQ-022 SHALL, at the end of STOP, go directly to START with a pop if the FIFO is non-empty (back-to-back frames, no idle gap), otherwise go to IDLE.
REQ-023 SHALL ignore cfg_* changes mid-frame; new values take effect at the next frame's latch.
REQ-024 SHALL, when a write and a pop occur on the same edge, leave fifo_level unchanged and keep the data correct; a write is never accepted while full.
REQ-025 SHALL wrap FIFO pointers modulo FIFO_DEPTH, with no data loss and no duplication.
REQ-026 SHALL keep uart_tx at 1 whenever the FSM is in IDLE.

Reset
REQ-027 SHALL, while rstn=0 at an edge, set the FSM to IDLE, empty the FIFO, set uart_tx=1, tx_busy=0 and fifo_level=0; s_valid is ignored during reset.
REQ-028 SHALL, on reset mid-frame, set uart_tx=1 at the next edge, abort the frame and discard all queued data; s_ready=1 from the first cycle after reset.

Verification
REQ-029 SHALL cover: cfg_div=3, 8N1, byte 0xA5 written while idle -> uart_tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; 40 cycles total; tx_busy then drops.
REQ-030 SHALL cover: 7E1, byte 0x41, cfg_div=1 -> line sequence 0,1,0,0,0,0,0,1, parity 0, stop 1; then 7O1 with the same byte -> parity 1.
REQ-031 SHALL cover: FIFO_DEPTH=4, 6 bytes 0x01..0x06 offered back-to-back -> s_ready drops at fifo_level=4; all six bytes are sent in order with no idle gap between frames.
REQ-032 SHALL cover: 5N2, cfg_div=0, byte 0xFF -> 0,1,1,1,1,1,1,1, each bit held 2 cycles; 16 cycles total.
REQ-033 SHALL cover: rstn pulsed low mid-DATA with 2 bytes queued -> uart_tx=1 at the next edge, fifo_level=0, tx_busy=0, and no further frame is sent.
REQ-034 SHALL cover: cfg_parity changed from none to even mid-frame -> current frame has no parity bit; next frame includes parity.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// FIFO-buffered UART transmitter. Word length, parity and stop bits are
// latched per frame when a word is popped, so mid-frame cfg changes are safe.
module uart_tx_cfg #(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [DIV_W-1:0]            cfg_div,
    input  logic [1:0]                  cfg_nbits,
    input  logic [1:0]                  cfg_parity,
    input  logic                        cfg_stop2,
    input  logic                        s_valid,
    input  logic [7:0]                  s_data,
    output logic                        s_ready,
    output logic                        uart_tx,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // Clears the bits above the configured word length (5..8 bits).
    function automatic logic [7:0] mask_word(input logic [7:0] w, input logic [1:0] nb);
        logic [7:0] m;
        m = 8'hFF >> (2'd3 - nb);
        return w & m;
    endfunction

    function automatic logic parity_bit(input logic [7:0] w, input logic [1:0] mode);
        return (^w) ^ (mode == 2'b10);
    endfunction

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic          fifo_nempty;
    logic [7:0]    fifo_rd;

    assign s_ready     = (count != FULL_LVL);
    assign push        = s_valid && s_ready;
    assign fifo_nempty = (count != '0);
    assign fifo_rd     = mem[rd_ptr];
    assign fifo_level  = count;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    state_t           state_q, state_n;
    logic [DIV_W-1:0] cnt_q, cnt_n;
    logic [2:0]       idx_q, idx_n;
    logic             stop_q, stop_n;
    logic             tx_q, tx_n;
    logic [7:0]       sh_q, sh_n;
    logic             par_bit_q, par_bit_n;
    logic             par_en_q, par_en_n;
    logic [1:0]       nbits_q, nbits_n;
    logic             stop2_q, stop2_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic             bit_done;
    logic             frame_start;
    logic [2:0]       last_idx;
    logic [7:0]       word_in;

    assign bit_done = (cnt_q == div_q);
    assign last_idx = {1'b0, nbits_q} + 3'd4;
    assign word_in  = mask_word(fifo_rd, cfg_nbits);
    assign uart_tx  = tx_q;
    assign tx_busy  = (state_q != IDLE) || fifo_nempty;

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        idx_n       = idx_q;
        stop_n      = stop_q;
        tx_n        = tx_q;
        sh_n        = sh_q;
        par_bit_n   = par_bit_q;
        par_en_n    = par_en_q;
        nbits_n     = nbits_q;
        stop2_n     = stop2_q;
        div_n       = div_q;
        pop         = 1'b0;
        frame_start = 1'b0;

        case (state_q)
            IDLE: begin
                tx_n  = 1'b1;
                cnt_n = '0;
                if (fifo_nempty) frame_start = 1'b1;
            end
            START: begin
                if (bit_done) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    tx_n    = sh_q[0];
                    state_n = DATA;
                end else begin
                    cnt_n = cnt_q + DIV_W'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_n = '0;
                    if (idx_q == last_idx) begin
                        if (par_en_q) begin
                            tx_n    = par_bit_q;
                            state_n = PARITY;
                        end else begin
                            tx_n    = 1'b1;
                            stop_n  = 1'b0;
                            state_n = STOP;
                        end
                    end else begin
                        // sh_q[0] is the bit on the line; shift the next one down
                        idx_n = idx_q + 3'd1;
                        tx_n  = sh_q[1];
                        sh_n  = sh_q >> 1;
                    end
                end else begin
                    cnt_n = cnt_q + DIV_W'(1);
                end
            end
            PARITY: begin
                if (bit_done) begin
                    cnt_n   = '0;
                    tx_n    = 1'b1;
                    stop_n  = 1'b0;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt_q + DIV_W'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    cnt_n = '0;
                    if (stop2_q && !stop_q) begin
                        stop_n = 1'b1;
                    end else if (fifo_nempty) begin
                        frame_start = 1'b1;
                    end else begin
                        tx_n    = 1'b1;
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt_q + DIV_W'(1);
                end
            end
            default: begin
                tx_n    = 1'b1;
                state_n = IDLE;
            end
        endcase

        // Pop and latch the whole frame configuration in one place.
        if (frame_start) begin
            pop       = 1'b1;
            state_n   = START;
            cnt_n     = '0;
            tx_n      = 1'b0;
            sh_n      = word_in;
            par_bit_n = parity_bit(word_in, cfg_parity);
            par_en_n  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            nbits_n   = cfg_nbits;
            stop2_n   = cfg_stop2;
            div_n     = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            stop_q  <= stop_n;
            tx_q    <= tx_n;
        end
    end

    always_ff @(posedge clk) begin
        sh_q      <= sh_n;
        par_bit_q <= par_bit_n;
        par_en_q  <= par_en_n;
        nbits_q   <= nbits_n;
        stop2_q   <= stop2_n;
        div_q     <= div_n;
    end

endmodule
